// File: rtl/ifetch_pkg.sv
// Fetch-stage types: FSM states, opcode constants and instruction-length decode.
package ifetch_pkg;
`include "global_defines.sv"

  typedef enum logic [2:0] {S_RST, S_OP, S_B1, S_B2, S_VALID, S_HALT} state_t;

  localparam logic [7:0] OP_NOP  = `OP_NOP;
  localparam logic [7:0] OP_LDAI = `OP_LDAI;
  localparam logic [7:0] OP_LDBI = `OP_LDBI;
  localparam logic [7:0] OP_LDA  = `OP_LDA;
  localparam logic [7:0] OP_STA  = `OP_STA;

  // Total bytes including the opcode; unknown opcodes are treated as 1-byte.
  function automatic logic [1:0] insn_len(input logic [7:0] op);
    case (op)
      `OP_LDAI, `OP_LDBI: insn_len = 2'd2;
      `OP_LDA,  `OP_STA:  insn_len = 2'd3;
      default:            insn_len = 2'd1;
    endcase
  endfunction

  function automatic logic insn_known(input logic [7:0] op);
    case (op)
      `OP_NOP, `OP_LDAI, `OP_LDBI, `OP_LDA, `OP_STA: insn_known = 1'b1;
      default:                                       insn_known = 1'b0;
    endcase
  endfunction
endpackage

// File: rtl/global_defines.sv
// TinyMCU-wide opcode encodings shared by the fetch stage, the decoder and the benches.
`ifndef GLOBAL_DEFINES_SV
`define GLOBAL_DEFINES_SV
`define OP_NOP  8'h00
`define OP_LDAI 8'h10
`define OP_LDBI 8'h11
`define OP_LDA  8'h20
`define OP_STA  8'h21
`endif

// File: rtl/instr_fetch.sv
// Fetch stage: reads 1-3 program bytes from RAM and presents one instruction word; IFETCH_ILLEGAL_OP_EN adds halt on unknown opcodes.
// Latency: 1/2/3 cycles from opcode fetch to instr_valid; one idle bus cycle per instruction.
// Backpressure: word held in S_VALID with the bus idle until instr_ready; jump_en overrides everything.
module instr_fetch
  import ifetch_pkg::*;
#(
  parameter logic [2:0]  RAM_DEVICE   = 3'b001,
  parameter logic [15:0] RESET_VECTOR = 16'h0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [2:0]  device_select,
  output logic [15:0] addr_out,
  output logic        oe,
  input  logic [7:0]  data_in,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [7:0]  opcode,
  output logic [15:0] operand,
  output logic [15:0] instr_pc,
  input  logic        jump_en,
  input  logic [15:0] jump_addr,
  output logic        illegal_op
);

  state_t      state;
  logic [15:0] pc;
  logic        fetching;

  // Bus is decoded from state so an asynchronous reset idles it immediately.
  assign fetching      = (state == S_OP) || (state == S_B1) || (state == S_B2);
  assign oe            = fetching;
  assign device_select = fetching ? RAM_DEVICE : 3'b000;
  assign addr_out      = fetching ? pc : 16'h0000;
  assign instr_valid   = (state == S_VALID);

`ifdef IFETCH_ILLEGAL_OP_EN
  logic illegal_q;
  assign illegal_op = illegal_q;
`else
  assign illegal_op = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_RST;
      pc       <= RESET_VECTOR;
      opcode   <= 8'h00;
      operand  <= 16'h0000;
      instr_pc <= 16'h0000;
`ifdef IFETCH_ILLEGAL_OP_EN
      illegal_q <= 1'b0;
`endif
    end else if (jump_en && state != S_RST) begin
      // Redirect discards any partial fetch and also consumes a pending word.
      pc    <= jump_addr;
      state <= S_OP;
`ifdef IFETCH_ILLEGAL_OP_EN
      illegal_q <= 1'b0;
`endif
    end else begin
      case (state)
        S_RST: state <= S_OP;
        S_OP: begin
          opcode   <= data_in;
          instr_pc <= pc;
          operand  <= 16'h0000;
          pc       <= pc + 16'd1;
`ifdef IFETCH_ILLEGAL_OP_EN
          if (!insn_known(data_in)) begin
            illegal_q <= 1'b1;
            state     <= S_HALT;
          end else
`endif
          if (insn_len(data_in) == 2'd1) state <= S_VALID;
          else                           state <= S_B1;
        end
        S_B1: begin
          operand[7:0] <= data_in;
          pc           <= pc + 16'd1;
          state        <= (insn_len(opcode) == 2'd2) ? S_VALID : S_B2;
        end
        S_B2: begin
          operand[15:8] <= data_in;
          pc            <= pc + 16'd1;
          state         <= S_VALID;
        end
        S_VALID: if (instr_ready) state <= S_OP;
`ifdef IFETCH_ILLEGAL_OP_EN
        S_HALT: state <= S_HALT;
`endif
        default: state <= S_RST;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: one DUT at reset vector 0, one at 16'hFFFF for PC wrap.
module tb_instr_fetch;
  import ifetch_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // DUT A, reset vector 0
  logic [2:0] ds_a; logic [15:0] addr_a; logic oe_a; logic [7:0] din_a;
  logic vld_a, rdy_a, ill_a, jmp_a; logic [7:0] op_a; logic [15:0] opd_a, ipc_a, jaddr_a;
  // DUT B, reset vector 16'hFFFF
  logic [2:0] ds_b; logic [15:0] addr_b; logic oe_b; logic [7:0] din_b;
  logic vld_b, rdy_b, ill_b, jmp_b; logic [7:0] op_b; logic [15:0] opd_b, ipc_b, jaddr_b;

  logic [7:0] mem_a [256];
  logic [7:0] mem_b [256];
  assign din_a = (oe_a && ds_a == 3'b001) ? mem_a[addr_a[7:0]] : 8'h00;
  assign din_b = (oe_b && ds_b == 3'b001) ? mem_b[addr_b[7:0]] : 8'h00;

  instr_fetch #(.RAM_DEVICE(3'b001), .RESET_VECTOR(16'h0000)) dut_a (
    .clk(clk), .rst_n(rst_n), .device_select(ds_a), .addr_out(addr_a), .oe(oe_a),
    .data_in(din_a), .instr_valid(vld_a), .instr_ready(rdy_a), .opcode(op_a),
    .operand(opd_a), .instr_pc(ipc_a), .jump_en(jmp_a), .jump_addr(jaddr_a), .illegal_op(ill_a));

  instr_fetch #(.RAM_DEVICE(3'b001), .RESET_VECTOR(16'hFFFF)) dut_b (
    .clk(clk), .rst_n(rst_n), .device_select(ds_b), .addr_out(addr_b), .oe(oe_b),
    .data_in(din_b), .instr_valid(vld_b), .instr_ready(rdy_b), .opcode(op_b),
    .operand(opd_b), .instr_pc(ipc_b), .jump_en(jmp_b), .jump_addr(jaddr_b), .illegal_op(ill_b));

  int checks = 0;
  int errors = 0;

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic wait_valid(input int maxc);
    int n;
    n = 0;
    while (!vld_a && n < maxc) begin
      step();
      n++;
    end
    checks++; if (vld_a !== 1'b1) begin errors++; $display("FAIL wait_valid: instr_valid=%b required 1", vld_a); end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; rdy_a = 1'b0; jmp_a = 1'b0; jaddr_a = 16'h0;
    rdy_b = 1'b0; jmp_b = 1'b0; jaddr_b = 16'h0;
    repeat (2) @(negedge clk);
    checks++; if ({oe_a, ds_a, addr_a} !== 20'h0) begin errors++; $display("FAIL reset_bus: oe=%b ds=%h addr=%h required 0", oe_a, ds_a, addr_a); end
    checks++; if ({vld_a, ill_a, op_a, opd_a, ipc_a} !== 42'h0) begin errors++; $display("FAIL reset_regs: vld=%b ill=%b op=%h opd=%h ipc=%h required 0", vld_a, ill_a, op_a, opd_a, ipc_a); end
    // Jump during reset / S_RST must be ignored
    jmp_a = 1'b1; jaddr_a = 16'h0055;
    rst_n = 1'b1;
    #1;
    checks++; if (oe_a !== 1'b0) begin errors++; $display("FAIL rst_idle_cycle: oe=%b required 0", oe_a); end
    step();
    jmp_a = 1'b0;
    checks++; if ({oe_a, ds_a, addr_a} !== {1'b1, 3'b001, 16'h0000}) begin errors++; $display("FAIL first_fetch: oe=%b ds=%h addr=%h required 1/1/0000", oe_a, ds_a, addr_a); end
  endtask

  task automatic test_nop_ldai();
    step();
    checks++; if ({vld_a, op_a, ipc_a, oe_a} !== {1'b1, OP_NOP, 16'h0000, 1'b0}) begin errors++; $display("FAIL nop_word: vld=%b op=%h ipc=%h oe=%b required 1/00/0000/0", vld_a, op_a, ipc_a, oe_a); end
    rdy_a = 1'b1;
    step();
    rdy_a = 1'b0;
    checks++; if ({vld_a, addr_a} !== {1'b0, 16'h0001}) begin errors++; $display("FAIL nop_consumed: vld=%b addr=%h required 0/0001", vld_a, addr_a); end
    step();
    checks++; if ({vld_a, addr_a} !== {1'b0, 16'h0002}) begin errors++; $display("FAIL ldai_b1: vld=%b addr=%h required 0/0002", vld_a, addr_a); end
    step();
    checks++; if ({vld_a, op_a, opd_a, ipc_a} !== {1'b1, OP_LDAI, 16'h0003, 16'h0001}) begin errors++; $display("FAIL ldai_word: vld=%b op=%h opd=%h ipc=%h required 1/10/0003/0001", vld_a, op_a, opd_a, ipc_a); end
  endtask

  task automatic test_backpressure();
    rdy_a = 1'b1;
    step();
    rdy_a = 1'b0;
    wait_valid(6);
    for (int i = 0; i < 5; i++) begin
      checks++; if ({vld_a, op_a, opd_a, ipc_a, oe_a} !== {1'b1, OP_STA, 16'h00F0, 16'h0003, 1'b0}) begin errors++; $display("FAIL sta_hold[%0d]: vld=%b op=%h opd=%h ipc=%h oe=%b required 1/21/00f0/0003/0", i, vld_a, op_a, opd_a, ipc_a, oe_a); end
      step();
    end
  endtask

  task automatic test_jump_abort();
    rdy_a = 1'b1;
    step();
    rdy_a = 1'b0;
    step();
    checks++; if ({oe_a, addr_a} !== {1'b1, 16'h0007}) begin errors++; $display("FAIL lda_b1: oe=%b addr=%h required 1/0007", oe_a, addr_a); end
    jmp_a = 1'b1; jaddr_a = 16'h0080;
    step();
    jmp_a = 1'b0;
    checks++; if ({vld_a, oe_a, addr_a} !== {1'b0, 1'b1, 16'h0080}) begin errors++; $display("FAIL jump_target: vld=%b oe=%b addr=%h required 0/1/0080", vld_a, oe_a, addr_a); end
    wait_valid(4);
    checks++; if ({op_a, opd_a, ipc_a} !== {OP_LDBI, 16'h0077, 16'h0080}) begin errors++; $display("FAIL after_jump_word: op=%h opd=%h ipc=%h required 11/0077/0080", op_a, opd_a, ipc_a); end
  endtask

  task automatic test_back_to_back();
    // Jump and handshake together: jump wins, word consumed
    rdy_a = 1'b1; jmp_a = 1'b1; jaddr_a = 16'h0090;
    step();
    rdy_a = 1'b0; jmp_a = 1'b0;
    checks++; if ({vld_a, oe_a, addr_a} !== {1'b0, 1'b1, 16'h0090}) begin errors++; $display("FAIL jump_vs_ready: vld=%b oe=%b addr=%h required 0/1/0090", vld_a, oe_a, addr_a); end
  endtask

  task automatic test_illegal();
    step();
`ifdef IFETCH_ILLEGAL_OP_EN
    for (int i = 0; i < 3; i++) begin
      checks++; if ({ill_a, oe_a, vld_a} !== 3'b100) begin errors++; $display("FAIL halt[%0d]: ill=%b oe=%b vld=%b required 1/0/0", i, ill_a, oe_a, vld_a); end
      step();
    end
    jmp_a = 1'b1; jaddr_a = 16'h0000;
    step();
    jmp_a = 1'b0;
    checks++; if ({ill_a, oe_a, addr_a} !== {1'b0, 1'b1, 16'h0000}) begin errors++; $display("FAIL halt_exit: ill=%b oe=%b addr=%h required 0/1/0000", ill_a, oe_a, addr_a); end
    wait_valid(4);
    checks++; if ({op_a, ipc_a} !== {OP_NOP, 16'h0000}) begin errors++; $display("FAIL resume_word: op=%h ipc=%h required 00/0000", op_a, ipc_a); end
`else
    checks++; if ({vld_a, op_a, opd_a, ipc_a, ill_a} !== {1'b1, 8'hEE, 16'h0000, 16'h0090, 1'b0}) begin errors++; $display("FAIL unknown_1byte: vld=%b op=%h opd=%h ipc=%h ill=%b required 1/ee/0000/0090/0", vld_a, op_a, opd_a, ipc_a, ill_a); end
`endif
  endtask

  task automatic test_reset_midfetch();
    jmp_a = 1'b1; jaddr_a = 16'h0003;
    step();
    jmp_a = 1'b0;
    step();
    step();
    checks++; if ({oe_a, addr_a} !== {1'b1, 16'h0005}) begin errors++; $display("FAIL sta_b2: oe=%b addr=%h required 1/0005", oe_a, addr_a); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if ({oe_a, ds_a, addr_a, op_a, opd_a} !== 44'h0) begin errors++; $display("FAIL async_reset: oe=%b ds=%h addr=%h op=%h opd=%h required 0", oe_a, ds_a, addr_a, op_a, opd_a); end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++; if (oe_a !== 1'b0) begin errors++; $display("FAIL post_reset_idle: oe=%b required 0", oe_a); end
    step();
    checks++; if ({oe_a, addr_a} !== {1'b1, 16'h0000}) begin errors++; $display("FAIL refetch_vector: oe=%b addr=%h required 1/0000", oe_a, addr_a); end
    step();
    checks++; if ({vld_a, op_a, ipc_a} !== {1'b1, OP_NOP, 16'h0000}) begin errors++; $display("FAIL refetch_word: vld=%b op=%h ipc=%h required 1/00/0000", vld_a, op_a, ipc_a); end
  endtask

  task automatic test_wrap();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    step();
    checks++; if ({oe_b, addr_b} !== {1'b1, 16'hFFFF}) begin errors++; $display("FAIL wrap_op: oe=%b addr=%h required 1/ffff", oe_b, addr_b); end
    step();
    checks++; if ({oe_b, addr_b} !== {1'b1, 16'h0000}) begin errors++; $display("FAIL wrap_b1: oe=%b addr=%h required 1/0000", oe_b, addr_b); end
    step();
    checks++; if ({vld_b, op_b, opd_b, ipc_b} !== {1'b1, OP_LDAI, 16'h005A, 16'hFFFF}) begin errors++; $display("FAIL wrap_word: vld=%b op=%h opd=%h ipc=%h required 1/10/005a/ffff", vld_b, op_b, opd_b, ipc_b); end
    rdy_b = 1'b1;
    step();
    rdy_b = 1'b0;
    checks++; if ({vld_b, addr_b} !== {1'b0, 16'h0001}) begin errors++; $display("FAIL wrap_pc: vld=%b addr=%h required 0/0001", vld_b, addr_b); end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      mem_a[i] = 8'h00;
      mem_b[i] = 8'h00;
    end
    mem_a[0] = OP_NOP;  mem_a[1] = OP_LDAI; mem_a[2] = 8'h03;
    mem_a[3] = OP_STA;  mem_a[4] = 8'hF0;   mem_a[5] = 8'h00;
    mem_a[6] = OP_LDA;  mem_a[7] = 8'h11;   mem_a[8] = 8'h22;
    mem_a[8'h80] = OP_LDBI; mem_a[8'h81] = 8'h77;
    mem_a[8'h90] = 8'hEE;
    mem_b[8'hFF] = OP_LDAI; mem_b[8'h00] = 8'h5A; mem_b[8'h01] = OP_NOP;

    test_reset();
    test_nop_ldai();
    test_backpressure();
    test_jump_abort();
    test_back_to_back();
    test_illegal();
    test_reset_midfetch();
    test_wrap();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete within 100000 time units");
    $fatal(1);
  end

endmodule
